bin2bcd_4dig: RTL and testbench

Sequential binary-to-BCD converter that turns the binary occupancy count into four packed BCD digits for the 4-digit seven-segment display driver. It sits directly upstream of the display multiplexer: its `bcd_out` drives the display's 16-bit BCD input. Conversion uses iterative double-dabble, one shift per clock. Inputs above 9999 saturate to 9999 and raise an overflow flag.

---
 rtl/bin2bcd_4dig_pkg.sv | 22 ++
 rtl/bin2bcd_4dig_add3.sv | 23 ++
 rtl/bin2bcd_4dig.sv | 129 ++++++++++++
 tb/tb_bin2bcd_4dig.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/bin2bcd_4dig_pkg.sv
// ---------------------------------------------------------------------------
// bin2bcd_4dig_pkg
//   Shared constants and state encoding for the binary-to-BCD converter and
//   the display-side blocks that consume its result.
//
//   BCD_MAX_VAL : largest value representable in four BCD digits
//   BCD_DIGITS  : number of packed BCD digits on the result bus
//   BCD_W       : width of the packed BCD result
//   bcd_state_e : converter state encoding (IDLE, SHIFT)
// ---------------------------------------------------------------------------
package bin2bcd_4dig_pkg;

    localparam int BCD_MAX_VAL = 9999;
    localparam int BCD_DIGITS  = 4;
    localparam int BCD_W       = 4 * BCD_DIGITS;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } bcd_state_e;

endpackage : bin2bcd_4dig_pkg

// File: rtl/bin2bcd_4dig_add3.sv
// ---------------------------------------------------------------------------
// bcd_add3
//   Combinational double-dabble correction cell: a BCD nibble that is 5 or
//   more gets +3 so that the following left shift carries into the next
//   digit instead of producing an illegal code.
//
//   d_in  : scratch nibble before correction
//   d_out : corrected nibble
// ---------------------------------------------------------------------------
module bcd_add3 (
    input  logic [3:0] d_in,
    output logic [3:0] d_out
);

    always_comb begin
        if (d_in >= 4'd5) begin
            d_out = d_in + 4'd3;
        end else begin
            d_out = d_in;
        end
    end

endmodule : bcd_add3

// File: rtl/bin2bcd_4dig.sv
// ---------------------------------------------------------------------------
// bin2bcd_4dig
//   Sequential binary-to-BCD converter (iterative double-dabble, one shift
//   per clock). Inputs above 9999 saturate to 9999 and raise ovf. The result
//   and ovf are only updated on the final iteration, so the display driver
//   never sees a partially converted value.
//
//   clk     : system clock, rising edge
//   reset   : asynchronous active-low reset
//   start   : conversion request, sampled only while idle
//   bin_in  : unsigned binary value, sampled on the accepting edge
//   busy    : high while a conversion is in progress
//   done    : one-cycle pulse when bcd_out/ovf have been updated
//   bcd_out : packed BCD result, [3:0] least significant digit
//   ovf     : last accepted bin_in exceeded 9999
// ---------------------------------------------------------------------------
module bin2bcd_4dig
    import bin2bcd_4dig_pkg::*;
#(
    parameter int BIN_W = 14
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [BIN_W-1:0] bin_in,
    output logic             busy,
    output logic             done,
    output logic [BCD_W-1:0] bcd_out,
    output logic             ovf
);

    localparam int               CNT_W     = $clog2(BIN_W + 1);
    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(BIN_W - 1);
    // Only reachable when BIN_W is wide enough to exceed 9999.
    localparam logic [BIN_W-1:0] SAT_VAL   = BIN_W'(BCD_MAX_VAL);

    bcd_state_e       state_q,   state_d;
    logic [BIN_W-1:0] work_q,    work_d;
    logic [BCD_W-1:0] scratch_q, scratch_d;
    logic [CNT_W-1:0] cnt_q,     cnt_d;
    logic             pend_q,    pend_d;
    logic [BCD_W-1:0] bcd_q,     bcd_d;
    logic             ovf_q,     ovf_d;
    logic             done_q,    done_d;

    logic [BCD_W-1:0] scratch_adj;
    logic [BCD_W-1:0] scratch_nxt;
    logic             in_over;

    // Adjust stage: one correction cell per digit.
    for (genvar gi = 0; gi < BCD_DIGITS; gi++) begin : g_add3
        bcd_add3 u_add3 (
            .d_in  (scratch_q[4*gi +: 4]),
            .d_out (scratch_adj[4*gi +: 4])
        );
    end

    // Shift stage: MSB of the working register enters the scratch LSB.
    assign scratch_nxt = {scratch_adj[BCD_W-2:0], work_q[BIN_W-1]};

    assign in_over = (32'(bin_in) > 32'(BCD_MAX_VAL));

    always_comb begin
        state_d   = state_q;
        work_d    = work_q;
        scratch_d = scratch_q;
        cnt_d     = cnt_q;
        pend_d    = pend_q;
        bcd_d     = bcd_q;
        ovf_d     = ovf_q;
        done_d    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    work_d    = in_over ? SAT_VAL : bin_in;
                    pend_d    = in_over;
                    scratch_d = '0;
                    cnt_d     = '0;
                    state_d   = ST_SHIFT;
                end
            end

            ST_SHIFT: begin
                scratch_d = scratch_nxt;
                work_d    = work_q << 1;
                cnt_d     = cnt_q + CNT_W'(1);
                if (cnt_q == LAST_ITER) begin
                    bcd_d   = scratch_nxt;
                    ovf_d   = pend_q;
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            work_q    <= '0;
            scratch_q <= '0;
            cnt_q     <= '0;
            pend_q    <= 1'b0;
            bcd_q     <= '0;
            ovf_q     <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            work_q    <= work_d;
            scratch_q <= scratch_d;
            cnt_q     <= cnt_d;
            pend_q    <= pend_d;
            bcd_q     <= bcd_d;
            ovf_q     <= ovf_d;
            done_q    <= done_d;
        end
    end

    assign busy    = (state_q == ST_SHIFT);
    assign done    = done_q;
    assign bcd_out = bcd_q;
    assign ovf     = ovf_q;

endmodule : bin2bcd_4dig

// File: tb/tb_bin2bcd_4dig.sv
// ---------------------------------------------------------------------------
// tb_bin2bcd_4dig
//   Directed self-checking bench for bin2bcd_4dig at BIN_W = 14.
// ---------------------------------------------------------------------------
module tb_bin2bcd_4dig;

    localparam int BIN_W = 14;

    logic             clk;
    logic             reset;
    logic             start;
    logic [BIN_W-1:0] bin_in;
    logic             busy;
    logic             done;
    logic [15:0]      bcd_out;
    logic             ovf;

    int n_vec;
    int n_err;

    logic [15:0] last_bcd;
    logic        last_ovf;

    bin2bcd_4dig #(.BIN_W(BIN_W)) u_dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .bin_in  (bin_in),
        .busy    (busy),
        .done    (done),
        .bcd_out (bcd_out),
        .ovf     (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic watch_no_done(input string tag, input int ncyc);
        int extra;
        extra = 0;
        for (int i = 0; i < ncyc; i++) begin
            @(negedge clk);
            if (done) extra++;
        end
        chk(tag, extra, 0);
    endtask

    // Drives one start pulse at a negedge and follows the conversion to done.
    task automatic run_conv(input logic [BIN_W-1:0] val, input logic [15:0] exp_bcd,
                            input logic exp_ovf, input bit inject);
        int cyc, busy_cyc, hold_err;
        bin_in = val;
        start  = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc   = 1;
        chk("busy_rise", busy, 1);
        busy_cyc = 0;
        hold_err = 0;
        while (!done && cyc < 40) begin
            if (busy) busy_cyc++;
            if (bcd_out !== last_bcd || ovf !== last_ovf) hold_err++;
            if (inject && cyc == 5) begin
                bin_in = 14'd1111;
                start  = 1'b1;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
        chk("done_latency", cyc, 15);
        chk("busy_cycles", busy_cyc, 14);
        chk("hold_during_busy", hold_err, 0);
        chk("bcd_out", bcd_out, exp_bcd);
        chk("ovf", ovf, exp_ovf);
        chk("busy_fall", busy, 0);
        last_bcd = exp_bcd;
        last_ovf = exp_ovf;
        watch_no_done("extra_done", 20);
    endtask

    logic [13:0] sw_val [7] = '{14'd0, 14'd9, 14'd10, 14'd99, 14'd100, 14'd9999, 14'd1234};
    logic [15:0] sw_bcd [7] = '{16'h0000, 16'h0009, 16'h0010, 16'h0099, 16'h0100, 16'h9999, 16'h1234};

    initial begin
        int dones, first_i, prev_i, spc_err;
        n_vec    = 0;
        n_err    = 0;
        last_bcd = 16'h0000;
        last_ovf = 1'b0;

        // Reset held with start asserted.
        reset  = 1'b0;
        start  = 1'b1;
        bin_in = 14'd1234;
        repeat (3) @(negedge clk);
        chk("rst_bcd", bcd_out, 16'h0000);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_ovf", ovf, 0);
        reset = 1'b1;
        start = 1'b0;
        repeat (3) @(negedge clk);
        chk("post_rst_busy", busy, 0);
        chk("post_rst_done", done, 0);

        for (int i = 0; i < 7; i++) begin
            run_conv(sw_val[i], sw_bcd[i], 1'b0, 1'b0);
        end

        run_conv(14'd12000, 16'h9999, 1'b1, 1'b0);
        run_conv(14'd42,    16'h0042, 1'b0, 1'b0);

        run_conv(14'd5678,  16'h5678, 1'b0, 1'b1);

        // Reset after iteration 7 of a 4321 conversion.
        bin_in = 14'd4321;
        start  = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (7) @(negedge clk);
        reset = 1'b0;
        #1;
        chk("abort_bcd", bcd_out, 16'h0000);
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        chk("abort_ovf", ovf, 0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        last_bcd = 16'h0000;
        last_ovf = 1'b0;
        watch_no_done("abort_no_done", 20);
        run_conv(14'd4321, 16'h4321, 1'b0, 1'b0);

        // start held high for 45 cycles.
        bin_in  = 14'd777;
        start   = 1'b1;
        dones   = 0;
        first_i = 0;
        prev_i  = 0;
        spc_err = 0;
        for (int i = 1; i <= 45; i++) begin
            @(negedge clk);
            if (done) begin
                dones++;
                if (first_i == 0) first_i = i;
                if (prev_i != 0 && (i - prev_i) != 15) spc_err++;
                prev_i = i;
            end
        end
        start = 1'b0;
        chk("held_done_count", dones, 3);
        chk("held_first_done", first_i, 15);
        chk("held_spacing", spc_err, 0);
        chk("held_bcd", bcd_out, 16'h0777);
        watch_no_done("held_tail", 20);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_bin2bcd_4dig
